// File: rtl/segre_pkg.sv
// Shared Segre core types and constants used by the pipeline controller.
package segre_pkg;

    localparam int unsigned REG_SIZE      = 5;
    localparam int unsigned PCTRL_FLUSH_W = 3;

    typedef enum logic [1:0] {
        PC_RUN      = 2'd0,
        PC_MEM_WAIT = 2'd1,
        PC_FLUSH    = 2'd2
    } pctrl_state_e;

endpackage

// File: rtl/segre_pipeline_ctrl_if.sv
// Hazard inputs from the stage chain and per-stage freeze/bubble controls back to it.
interface segre_pipeline_ctrl_if #(
    parameter int unsigned REG_SIZE = segre_pkg::REG_SIZE
);
    logic                valid_ex_i;
    logic                memop_rd_ex_i;
    logic [REG_SIZE-1:0] rf_waddr_ex_i;
    logic [REG_SIZE-1:0] rf_raddr_a_id_i;
    logic [REG_SIZE-1:0] rf_raddr_b_id_i;
    logic                rf_re_a_id_i;
    logic                rf_re_b_id_i;
    logic                valid_id_i;
    logic                tkbr_i;
    logic                is_jaljalr_i;
    logic                mem_req_i;
    logic                mem_ready_i;

    logic                redirect_o;
    logic                block_if_o;
    logic                block_id_o;
    logic                block_ex_o;
    logic                block_mem_o;
    logic                inject_nops_id_o;
    logic                inject_nops_ex_o;
    logic                inject_nops_mem_o;
    logic                inject_nops_wb_o;
    logic [1:0]          state_o;

    // Controller side
    modport master (
        input  valid_ex_i, memop_rd_ex_i, rf_waddr_ex_i, rf_raddr_a_id_i,
               rf_raddr_b_id_i, rf_re_a_id_i, rf_re_b_id_i, valid_id_i,
               tkbr_i, is_jaljalr_i, mem_req_i, mem_ready_i,
        output redirect_o, block_if_o, block_id_o, block_ex_o, block_mem_o,
               inject_nops_id_o, inject_nops_ex_o, inject_nops_mem_o,
               inject_nops_wb_o, state_o
    );

    // Stage-chain side
    modport slave (
        output valid_ex_i, memop_rd_ex_i, rf_waddr_ex_i, rf_raddr_a_id_i,
               rf_raddr_b_id_i, rf_re_a_id_i, rf_re_b_id_i, valid_id_i,
               tkbr_i, is_jaljalr_i, mem_req_i, mem_ready_i,
        input  redirect_o, block_if_o, block_id_o, block_ex_o, block_mem_o,
               inject_nops_id_o, inject_nops_ex_o, inject_nops_mem_o,
               inject_nops_wb_o, state_o
    );

endinterface

// File: rtl/segre_hazard_detect.sv
// Combinational hazard terms: load-use (lu), redirect (rd), memory wait (mw).
module segre_hazard_detect #(
    parameter int unsigned REG_SIZE = segre_pkg::REG_SIZE
) (
    input  logic                valid_ex_i,
    input  logic                memop_rd_ex_i,
    input  logic [REG_SIZE-1:0] rf_waddr_ex_i,
    input  logic [REG_SIZE-1:0] rf_raddr_a_id_i,
    input  logic [REG_SIZE-1:0] rf_raddr_b_id_i,
    input  logic                rf_re_a_id_i,
    input  logic                rf_re_b_id_i,
    input  logic                valid_id_i,
    input  logic                tkbr_i,
    input  logic                is_jaljalr_i,
    input  logic                mem_req_i,
    input  logic                mem_ready_i,
    output logic                lu_o,
    output logic                rd_o,
    output logic                mw_o
);

    logic match_a, match_b;

    assign match_a = rf_re_a_id_i && (rf_raddr_a_id_i == rf_waddr_ex_i);
    assign match_b = rf_re_b_id_i && (rf_raddr_b_id_i == rf_waddr_ex_i);

    // x0 is hardwired, so a load targeting it never creates a dependency
    assign lu_o = valid_ex_i && memop_rd_ex_i && valid_id_i &&
                  (rf_waddr_ex_i != '0) && (match_a || match_b);
    assign rd_o = valid_ex_i && (tkbr_i || is_jaljalr_i);
    assign mw_o = mem_req_i && !mem_ready_i;

endmodule

// File: rtl/segre_pipeline_ctrl.sv
// Segre pipeline sequencing FSM: stalls, redirect flush window, memory waits.
// Define SEGRE_PIPE_PERF_EN to add stall/flush performance counters.
module segre_pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned REG_SIZE     = segre_pkg::REG_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rsn_i,
    segre_pipeline_ctrl_if.master bus
`ifdef SEGRE_PIPE_PERF_EN
    ,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           flush_count_o
`endif
);
    import segre_pkg::*;

    localparam logic [PCTRL_FLUSH_W-1:0] FLUSH_LD = PCTRL_FLUSH_W'(FLUSH_CYCLES);

    pctrl_state_e             state_q, state_d;
    logic [PCTRL_FLUSH_W-1:0] cnt_q, cnt_d;
    logic                     lu, rd, mw;

    logic redirect, b_if, b_id, b_ex, b_mem, n_id, n_ex, n_mem, n_wb;

    segre_hazard_detect #(.REG_SIZE(REG_SIZE)) u_hazard (
        .valid_ex_i      (bus.valid_ex_i),
        .memop_rd_ex_i   (bus.memop_rd_ex_i),
        .rf_waddr_ex_i   (bus.rf_waddr_ex_i),
        .rf_raddr_a_id_i (bus.rf_raddr_a_id_i),
        .rf_raddr_b_id_i (bus.rf_raddr_b_id_i),
        .rf_re_a_id_i    (bus.rf_re_a_id_i),
        .rf_re_b_id_i    (bus.rf_re_b_id_i),
        .valid_id_i      (bus.valid_id_i),
        .tkbr_i          (bus.tkbr_i),
        .is_jaljalr_i    (bus.is_jaljalr_i),
        .mem_req_i       (bus.mem_req_i),
        .mem_ready_i     (bus.mem_ready_i),
        .lu_o            (lu),
        .rd_o            (rd),
        .mw_o            (mw)
    );

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q <= PC_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        redirect = 1'b0;
        b_if     = 1'b0;
        b_id     = 1'b0;
        b_ex     = 1'b0;
        b_mem    = 1'b0;
        n_id     = 1'b0;
        n_ex     = 1'b0;
        n_mem    = 1'b0;
        n_wb     = 1'b0;

        if (rsn_i) begin
            n_id  = 1'b1;
            n_ex  = 1'b1;
            n_mem = 1'b1;
            n_wb  = 1'b1;
        end else if (mw) begin
            // Freeze everything; a pending flush count survives the wait
            b_if    = 1'b1;
            b_id    = 1'b1;
            b_ex    = 1'b1;
            b_mem   = 1'b1;
            n_wb    = 1'b1;
            state_d = PC_MEM_WAIT;
        end else if (state_q == PC_FLUSH) begin
            n_id = 1'b1;
            if (cnt_q <= PCTRL_FLUSH_W'(1)) begin
                state_d = PC_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            // PC_RUN, or the ready cycle of PC_MEM_WAIT which acts as PC_RUN
            if (rd) begin
                redirect = 1'b1;
                n_id     = 1'b1;
                n_ex     = 1'b1;
                cnt_d    = FLUSH_LD;
                state_d  = (FLUSH_CYCLES > 0) ? PC_FLUSH : PC_RUN;
            end else begin
                if (lu) begin
                    b_if = 1'b1;
                    b_id = 1'b1;
                    n_ex = 1'b1;
                end
                state_d = (state_q == PC_MEM_WAIT && cnt_q != '0) ? PC_FLUSH : PC_RUN;
            end
        end
    end

    assign bus.redirect_o        = redirect;
    assign bus.block_if_o        = b_if;
    assign bus.block_id_o        = b_id;
    assign bus.block_ex_o        = b_ex;
    assign bus.block_mem_o       = b_mem;
    assign bus.inject_nops_id_o  = n_id;
    assign bus.inject_nops_ex_o  = n_ex;
    assign bus.inject_nops_mem_o = n_mem;
    assign bus.inject_nops_wb_o  = n_wb;
    assign bus.state_o           = state_q;

`ifdef SEGRE_PIPE_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (b_if || b_id || b_ex || b_mem) stall_q <= stall_q + 32'd1;
            if (redirect)                      flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
    assign flush_count_o  = flush_q;
`endif

endmodule

// File: tb/tb_segre_pipeline_ctrl.sv
// Directed bench for segre_pipeline_ctrl with FLUSH_CYCLES=2.
module tb_segre_pipeline_ctrl;

    logic clk = 1'b0;
    logic rsn = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    segre_pipeline_ctrl_if #(.REG_SIZE(5)) bus ();

`ifdef SEGRE_PIPE_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    segre_pipeline_ctrl #(.FLUSH_CYCLES(2), .REG_SIZE(5)) dut (
        .clk_i (clk),
        .rsn_i (rsn),
        .bus   (bus)
`ifdef SEGRE_PIPE_PERF_EN
        ,
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
`endif
    );

    // {redirect, block_if, block_id, block_ex, block_mem, nop_id, nop_ex, nop_mem, nop_wb}
    wire [8:0] ctl = {bus.redirect_o, bus.block_if_o, bus.block_id_o, bus.block_ex_o,
                      bus.block_mem_o, bus.inject_nops_id_o, bus.inject_nops_ex_o,
                      bus.inject_nops_mem_o, bus.inject_nops_wb_o};

    localparam logic [8:0] C_IDLE  = 9'b0_0000_0000;
    localparam logic [8:0] C_RST   = 9'b0_0000_1111;
    localparam logic [8:0] C_LU    = 9'b0_1100_0100;
    localparam logic [8:0] C_RD    = 9'b1_0000_1100;
    localparam logic [8:0] C_FLUSH = 9'b0_0000_1000;
    localparam logic [8:0] C_MW    = 9'b0_1111_0001;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.valid_ex_i      = 1'b0;
        bus.memop_rd_ex_i   = 1'b0;
        bus.rf_waddr_ex_i   = '0;
        bus.rf_raddr_a_id_i = '0;
        bus.rf_raddr_b_id_i = '0;
        bus.rf_re_a_id_i    = 1'b0;
        bus.rf_re_b_id_i    = 1'b0;
        bus.valid_id_i      = 1'b0;
        bus.tkbr_i          = 1'b0;
        bus.is_jaljalr_i    = 1'b0;
        bus.mem_req_i       = 1'b0;
        bus.mem_ready_i     = 1'b0;
    endtask

    initial begin
        clr();
        #2;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        tick();
        chk("rst_state", 32'(bus.state_o), 0);
        rsn = 1'b0;
        #1;
        chk("idle_ctl", 32'(ctl), 32'(C_IDLE));

        // Load x5 in EX, add reads x5 via port b
        tick();
        bus.valid_ex_i = 1'b1; bus.memop_rd_ex_i = 1'b1; bus.rf_waddr_ex_i = 5'd5;
        bus.valid_id_i = 1'b1; bus.rf_raddr_a_id_i = 5'd3; bus.rf_re_a_id_i = 1'b1;
        bus.rf_raddr_b_id_i = 5'd5; bus.rf_re_b_id_i = 1'b1;
        #1;
        chk("lu_ctl", 32'(ctl), 32'(C_LU));
        tick();
        chk("lu_state", 32'(bus.state_o), 0);
        bus.valid_ex_i = 1'b0;
        #1;
        chk("lu_after", 32'(ctl), 32'(C_IDLE));

        // Address matches but port b not read
        bus.valid_ex_i = 1'b1; bus.rf_re_b_id_i = 1'b0;
        #1;
        chk("lu_noread", 32'(ctl), 32'(C_IDLE));

        // Load to x0 with ID reading x0
        bus.rf_waddr_ex_i = '0; bus.rf_raddr_a_id_i = '0; bus.rf_re_a_id_i = 1'b1;
        #1;
        chk("lu_x0", 32'(ctl), 32'(C_IDLE));
        tick();
        clr();

        // JAL flagged but EX not valid
        bus.is_jaljalr_i = 1'b1;
        #1;
        chk("jal_invalid", 32'(ctl), 32'(C_IDLE));
        clr();

        // Taken branch, two-cycle flush window
        bus.valid_ex_i = 1'b1; bus.tkbr_i = 1'b1;
        #1;
        chk("br_c0", 32'(ctl), 32'(C_RD));
        tick();
        clr();
        chk("br_c1_state", 32'(bus.state_o), 2);
        chk("br_c1_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("br_c2_state", 32'(bus.state_o), 2);
        chk("br_c2_ctl", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("br_c3_state", 32'(bus.state_o), 0);
        chk("br_c3_ctl", 32'(ctl), 32'(C_IDLE));

        // Memory wait of three cycles
        bus.mem_req_i = 1'b1; bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("mw_c%0d", i), 32'(ctl), 32'(C_MW));
            tick();
            chk($sformatf("mw_st%0d", i), 32'(bus.state_o), 1);
        end
        bus.mem_ready_i = 1'b1;
        #1;
        chk("mw_ready", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("mw_done", 32'(bus.state_o), 0);

        // Zero-wait access
        #1;
        chk("mw_zero", 32'(ctl), 32'(C_IDLE));
        tick();
        chk("mw_zero_st", 32'(bus.state_o), 0);
        clr();

        // Memory wait during flush keeps the remaining window
        bus.valid_ex_i = 1'b1; bus.tkbr_i = 1'b1;
        #1;
        chk("mwf_rd", 32'(ctl), 32'(C_RD));
        tick();
        clr();
        bus.mem_req_i = 1'b1;
        #1;
        chk("mwf_stall", 32'(ctl), 32'(C_MW));
        tick();
        chk("mwf_state", 32'(bus.state_o), 1);
        bus.mem_ready_i = 1'b1;
        #1;
        chk("mwf_ready", 32'(ctl), 32'(C_IDLE));
        tick();
        clr();
        chk("mwf_f1_st", 32'(bus.state_o), 2);
        chk("mwf_f1", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("mwf_f2", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("mwf_end", 32'(bus.state_o), 0);

        // Reset in the middle of a flush
        bus.valid_ex_i = 1'b1; bus.tkbr_i = 1'b1;
        tick();
        clr();
        chk("rstf_state", 32'(bus.state_o), 2);
        rsn = 1'b1;
        #1;
        chk("rstf_ctl", 32'(ctl), 32'(C_RST));
        tick();
        rsn = 1'b0;
        #1;
        chk("rstf_after_st", 32'(bus.state_o), 0);
        chk("rstf_after", 32'(ctl), 32'(C_IDLE));
`ifdef SEGRE_PIPE_PERF_EN
        chk("perf_rst_flush", flush_count, 0);
        chk("perf_rst_stall", stall_cycles, 0);
`endif

        // Memory wait and redirect together: stall first, redirect on ready
        bus.mem_req_i = 1'b1; bus.valid_ex_i = 1'b1; bus.tkbr_i = 1'b1;
        #1;
        chk("sim_c0", 32'(ctl), 32'(C_MW));
        tick();
        chk("sim_c1", 32'(ctl), 32'(C_MW));
        tick();
        bus.mem_ready_i = 1'b1;
        #1;
        chk("sim_ready", 32'(ctl), 32'(C_RD));
        tick();
        clr();
        chk("sim_f1_st", 32'(bus.state_o), 2);
        chk("sim_f1", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("sim_f2", 32'(ctl), 32'(C_FLUSH));
        tick();
        chk("sim_end", 32'(bus.state_o), 0);
`ifdef SEGRE_PIPE_PERF_EN
        chk("perf_flush", flush_count, 1);
        chk("perf_stall", stall_cycles, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
